tb_exit_responder: RTL and testbench

//  OBI data-bus responder in the core verification subsystem; the core (initiator) signals test outcome through it.

---
 rtl/tb_exit_pkg.sv | 44 ++++
 rtl/tb_char_fifo.sv | 60 ++++++
 rtl/tb_exit_responder.sv | 148 ++++++++++++++
 tb/tb_tb_exit_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tb_exit_pkg.sv
// Shared definitions for the exit responder: register offsets, magic values,
// STATUS field layout and the registered response record.
// Ports: none (package).
package tb_exit_pkg;

    // Register index within the 16-byte window (address bits [3:2]).
    localparam logic [1:0] REG_PRINT       = 2'd0;
    localparam logic [1:0] REG_TEST_STATUS = 2'd1;
    localparam logic [1:0] REG_EXIT        = 2'd2;
    localparam logic [1:0] REG_STATUS      = 2'd3;

    localparam logic [31:0] PASS_MAGIC_DEF = 32'd123456789;
    localparam logic [31:0] FAIL_MAGIC_DEF = 32'd1;

    // STATUS read layout.
    localparam int unsigned STATUS_FAILED_BIT = 0;
    localparam int unsigned STATUS_PASSED_BIT = 1;
    localparam int unsigned STATUS_EMPTY_BIT  = 2;
    localparam int unsigned STATUS_COUNT_LSB  = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } resp_state_e;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    function automatic logic [31:0] status_word(input logic [7:0] count,
                                                input logic       empty,
                                                input logic       passed,
                                                input logic       failed);
        logic [31:0] w;
        w = '0;
        w[STATUS_COUNT_LSB +: 8]  = count;
        w[STATUS_EMPTY_BIT]       = empty;
        w[STATUS_PASSED_BIT]      = passed;
        w[STATUS_FAILED_BIT]      = failed;
        return w;
    endfunction

endpackage

// File: rtl/tb_char_fifo.sv
// Purpose: synchronous FIFO holding characters written to the PRINT register.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; full_o lets the writer stall.
// Ports: clk_i/rst_i (sync, active high); push_i/push_dat_i write side;
//        pop_i/head_dat_o read side; full_o, empty_o, count_o occupancy.
module tb_char_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: contents are only observed while non-empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/tb_exit_responder.sv
// Purpose: OBI data responder decoding PRINT/TEST_STATUS/EXIT/STATUS for the core bench.
// Latency: grant combinational, response exactly one cycle after accept.
// Backpressure: PRINT writes are not granted while the character FIFO is full.
// Ports: clk_i/rst_i; OBI data_* request/response; char_* FIFO drain to stdout model;
//        tests_passed_o/tests_failed_o sticky flags; exit_valid_o pulse with exit_value_o.
module tb_exit_responder
    import tb_exit_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] PASS_MAGIC = PASS_MAGIC_DEF,
    parameter logic [31:0] FAIL_MAGIC = FAIL_MAGIC_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        char_valid_o,
    output logic [7:0]  char_o,
    input  logic        char_ready_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          in_win;
    logic [1:0]    reg_idx;
    logic          acc_err;
    logic          print_wr;
    logic          accept;
    logic          wr_ok;
    logic          push, pop;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic [31:0]   rdata_acc;
    logic          unused_be;

    resp_state_e   state_q, state_d;
    resp_t         resp_q, resp_d;

    logic          passed_q, failed_q;
    logic          exit_vld_q;
    logic [31:0]   exit_val_q;

    // Only the low byte lane carries a PRINT character.
    assign unused_be = ^data_be_i[3:1];

    // ---------------- decode ----------------
    assign in_win  = (data_addr_i & ~32'hF) == BASE_ADDR;
    assign reg_idx = data_addr_i[3:2];
    // STATUS is the only readable register; everything out of window errors.
    assign acc_err = ~in_win | (~data_we_i & (reg_idx != REG_STATUS));

    assign print_wr   = in_win & data_we_i & (reg_idx == REG_PRINT);
    // Full is a registered condition, so a same-cycle pop does not unblock the grant.
    assign data_gnt_o = data_req_i & ~(print_wr & fifo_full);
    assign accept     = data_req_i & data_gnt_o;
    assign wr_ok      = accept & data_we_i & ~acc_err;

    assign push = wr_ok & (reg_idx == REG_PRINT) & data_be_i[0];
    assign pop  = char_valid_o & char_ready_i;

    assign rdata_acc = (~acc_err & ~data_we_i & (reg_idx == REG_STATUS))
                     ? status_word(8'(fifo_cnt), fifo_empty, passed_q, failed_q)
                     : 32'h0;

    // ---------------- character FIFO ----------------
    tb_char_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_char_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push),
        .push_dat_i (data_wdata_i[7:0]),
        .pop_i      (pop),
        .head_dat_o (char_o),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt)
    );

    assign char_valid_o = ~fifo_empty;

    // ---------------- pending-response FSM ----------------
    always_comb begin
        state_d = state_q;
        resp_d  = resp_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RESP;
            ST_RESP: state_d = accept ? ST_RESP : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            resp_d.err   = acc_err;
            resp_d.rdata = rdata_acc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
        end
    end

    assign data_rvalid_o = (state_q == ST_RESP);
    assign data_err_o    = data_rvalid_o & resp_q.err;
    assign data_rdata_o  = data_rvalid_o ? resp_q.rdata : 32'h0;

    // ---------------- flags and exit ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            passed_q   <= 1'b0;
            failed_q   <= 1'b0;
            exit_vld_q <= 1'b0;
            exit_val_q <= '0;
        end else begin
            exit_vld_q <= 1'b0;
            if (wr_ok && reg_idx == REG_TEST_STATUS) begin
                if (data_wdata_i == PASS_MAGIC) passed_q <= 1'b1;
                if (data_wdata_i == FAIL_MAGIC) failed_q <= 1'b1;
            end
            if (wr_ok && reg_idx == REG_EXIT) begin
                exit_vld_q <= 1'b1;
                exit_val_q <= data_wdata_i;
            end
        end
    end

    assign tests_passed_o = passed_q;
    assign tests_failed_o = failed_q;
    assign exit_valid_o   = exit_vld_q;
    assign exit_value_o   = exit_val_q;

endmodule

// File: tb/tb_tb_exit_responder.sv
module tb_tb_exit_responder;
    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam int          DEPTH = 8;
    localparam logic [31:0] PASS  = 32'd123456789;
    localparam logic [31:0] FAILV = 32'd1;

    logic        clk;
    logic        rst_i;
    logic        data_req_i, data_we_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic [3:0]  data_be_i;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        char_valid_o, char_ready_i;
    logic [7:0]  char_o;
    logic        tests_passed_o, tests_failed_o, exit_valid_o;
    logic [31:0] exit_value_o;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    byte unsigned q[$];
    bit           m_pass, m_fail;
    bit           m_exit_pulse;
    bit [31:0]    m_exit_val;
    bit           m_rv, m_err;
    bit [31:0]    m_rdata;

    tb_exit_responder #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .PASS_MAGIC (PASS),
        .FAIL_MAGIC (FAILV)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_addr_i    (data_addr_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_wdata_i   (data_wdata_i),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .char_valid_o   (char_valid_o),
        .char_o         (char_o),
        .char_ready_i   (char_ready_i),
        .tests_passed_o (tests_passed_o),
        .tests_failed_o (tests_failed_o),
        .exit_valid_o   (exit_valid_o),
        .exit_value_o   (exit_value_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_pass = 0; m_fail = 0; m_exit_pulse = 0; m_exit_val = 0;
        m_rv = 0; m_err = 0; m_rdata = 0;
    endtask

    // One bus cycle: drive, check every output against the model, advance the model.
    task automatic step(input bit rst, input bit req, input bit we, input bit [31:0] addr,
                        input bit [3:0] be, input bit [31:0] wd, input bit rdy, output bit acc);
        bit        in_win, full, pw, g, e, do_push;
        bit [31:0] rd;
        int        off;
        rst_i = rst; data_req_i = req; data_we_i = we; data_addr_i = addr;
        data_be_i = be; data_wdata_i = wd; char_ready_i = rdy;
        @(negedge clk);
        in_win = (addr & ~32'hF) == BASE;
        off    = int'(addr[3:2]);
        full   = (q.size() == DEPTH);
        pw     = req && we && in_win && off == 0;
        g      = req && !(pw && full);
        chk("gnt", data_gnt_o, g);
        chk("rvalid", data_rvalid_o, m_rv);
        if (m_rv) begin
            chk("err", data_err_o, m_err);
            chk("rdata", data_rdata_o, m_rdata);
        end
        chk("char_valid", char_valid_o, q.size() != 0);
        if (q.size() != 0) chk("char", char_o, q[0]);
        chk("passed", tests_passed_o, m_pass);
        chk("failed", tests_failed_o, m_fail);
        chk("exit_valid", exit_valid_o, m_exit_pulse);
        chk("exit_value", exit_value_o, m_exit_val);
        acc = g;
        if (rst) begin
            model_clear();
        end else begin
            do_push = 0;
            m_exit_pulse = 0;
            m_rv = g;
            if (g) begin
                e  = !in_win || (!we && off != 3);
                rd = 0;
                if (!e && !we)
                    rd = {16'b0, 8'(q.size()), 5'b0, q.size() == 0, m_pass, m_fail};
                m_err = e; m_rdata = rd;
                if (!e && we) begin
                    if (off == 0 && be[0]) do_push = 1;
                    if (off == 1 && wd == PASS)  m_pass = 1;
                    if (off == 1 && wd == FAILV) m_fail = 1;
                    if (off == 2) begin m_exit_pulse = 1; m_exit_val = wd; end
                end
            end
            if (q.size() != 0 && rdy) void'(q.pop_front());
            if (do_push) q.push_back(wd[7:0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        bit a;
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 4'h0, 32'h0, rdy, a);
    endtask

    // Holds a write request until the grant arrives, within a cycle budget.
    task automatic write_hold(input bit [31:0] addr, input bit [31:0] wd, input bit [3:0] be, input bit rdy);
        bit a;
        int n;
        n = 0;
        a = 0;
        while (!a && n < 40) begin
            step(0, 1, 1, addr, be, wd, rdy, a);
            n++;
        end
        if (!a) chk("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_once(input bit [31:0] addr, input bit rdy);
        bit a;
        step(0, 1, 0, addr, 4'hF, 32'h0, rdy, a);
    endtask

    initial begin
        bit          a;
        int          sel;
        bit [31:0]   addr, wd;

        // Unchecked reset to bring outputs out of X, then checked reset cycle.
        rst_i = 1; data_req_i = 0; data_we_i = 0; data_addr_i = 0;
        data_be_i = 0; data_wdata_i = 0; char_ready_i = 0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        step(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, a);
        idle(1, 0);

        // 1: pass magic
        write_hold(BASE + 4, PASS, 4'hF, 0);
        idle(3, 0);

        // 2: exit code 42, pulse then hold
        write_hold(BASE + 8, 32'h0000_002A, 4'hF, 0);
        idle(3, 0);

        // 3: fill FIFO 'A'..'H', 'I' stalls, then drains in order
        for (int i = 0; i < 8; i++) write_hold(BASE, 32'h41 + i, 4'h1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, BASE, 4'h1, 32'h49, 0, a);
        write_hold(BASE, 32'h49, 4'h1, 1);
        idle(12, 1);

        // 4: STATUS read with 3 queued, out-of-window read, be[0]=0 PRINT
        for (int i = 0; i < 3; i++) write_hold(BASE, 32'h61 + i, 4'hF, 0);
        read_once(BASE + 12, 0);
        read_once(32'h1000_0000, 0);
        read_once(BASE, 0);
        write_hold(BASE, 32'h7A, 4'hE, 0);
        write_hold(32'h3000_0004, PASS, 4'hF, 0);
        idle(10, 1);

        // 5: back-to-back PRINT with consumer ready
        for (int i = 0; i < 10; i++) write_hold(BASE, 32'h30 + i, 4'h1, 1);
        idle(3, 1);

        // 6: reset lands on an accept
        write_hold(BASE + 4, FAILV, 4'hF, 0);
        write_hold(BASE, 32'h5A, 4'h1, 0);
        step(1, 1, 1, BASE + 8, 4'hF, 32'hDEAD_BEEF, 0, a);
        idle(3, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            sel = $urandom_range(0, 11);
            if (sel < 8)       addr = BASE + 32'(4 * (sel % 4));
            else if (sel == 8) addr = 32'h1000_0000 | ($urandom() & 32'hF);
            else if (sel == 9) addr = BASE + 32'h10;
            else               addr = BASE;
            case ($urandom_range(0, 5))
                0:       wd = PASS;
                1:       wd = FAILV;
                default: wd = $urandom();
            endcase
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 3) != 0), addr, 4'($urandom()), wd,
                 ($urandom_range(0, 2) == 0), a);
        end
        idle(20, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
